// File: rtl/dma_tx_pkg.sv
// Shared TX-side types: arbiter states, source indices and the idle TRN bundle.
package dma_tx_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StGap
  } tx_state_e;

  localparam int unsigned TX_SRC_CM = 0;
  localparam int unsigned TX_SRC_WR = 1;
  localparam int unsigned TX_SRC_RD = 2;

  localparam logic [63:0] TD_IDLE   = 64'h0;
  localparam logic [7:0]  TREM_IDLE = 8'hFF;

  typedef struct packed {
    logic [63:0] td;
    logic [7:0]  trem_n;
    logic        tsof_n;
    logic        teof_n;
    logic        tsrc_rdy_n;
  } trn_bundle_t;

  localparam trn_bundle_t TRN_IDLE = '{
    td:         TD_IDLE,
    trem_n:     TREM_IDLE,
    tsof_n:     1'b1,
    teof_n:     1'b1,
    tsrc_rdy_n: 1'b1
  };

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request after last_idx, wrapping at NumReq.
module rr_pick #(
  parameter int unsigned NumReq  = 3,
  parameter int unsigned IdxBits = 2
) (
  input  logic [NumReq-1:0]  req,
  input  logic [IdxBits-1:0] last_idx,
  output logic [IdxBits-1:0] winner,
  output logic               found
);

  logic [IdxBits-1:0] cand;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = last_idx;
    for (int unsigned off = 0; off < NumReq; off++) begin
      // Explicit wrap so a non-power-of-2 NumReq never selects a phantom index.
      if (cand == IdxBits'(NumReq - 1)) begin
        cand = '0;
      end else begin
        cand = cand + IdxBits'(1);
      end
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

endmodule

// File: rtl/pcie_tx_arb.sv
// Per-packet round-robin arbiter sharing the 64-bit TRN TX interface between packet sources,
// with credit/link gating, a per-packet watchdog and sticky error flags.
module pcie_tx_arb
  import dma_tx_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned REQ_BITS    = 2,
  parameter int unsigned WDOG_CYCLES = 1024,
  parameter int unsigned MIN_TBUF    = 1
) (
  input  logic                  pcie_clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_v,
  input  logic [NUM_REQ-1:0]    req_done,
  output logic [NUM_REQ-1:0]    req_grant,
  output logic                  req_stall,
  input  logic [64*NUM_REQ-1:0] src_td,
  input  logic [8*NUM_REQ-1:0]  src_trem_n,
  input  logic [NUM_REQ-1:0]    src_tsof_n,
  input  logic [NUM_REQ-1:0]    src_teof_n,
  input  logic [NUM_REQ-1:0]    src_tsrc_rdy_n,
  output logic [63:0]           trn_td,
  output logic [7:0]            trn_trem_n,
  output logic                  trn_tsof_n,
  output logic                  trn_teof_n,
  output logic                  trn_tsrc_rdy_n,
  input  logic                  trn_tdst_rdy_n,
  input  logic [5:0]            trn_tbuf_av,
  input  logic                  trn_lnk_up_n,
  output logic                  err_wdog,
  output logic                  err_lnk,
  input  logic                  err_clr
);

  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES);

  tx_state_e             state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [REQ_BITS-1:0]   grant_idx_q, grant_idx_d;
  logic [REQ_BITS-1:0]   last_idx_q, last_idx_d;
  logic [WDOG_W-1:0]     wdog_q, wdog_d;
  logic                  err_wdog_q, err_wdog_d;
  logic                  err_lnk_q, err_lnk_d;

  logic                  wdog_fire;
  logic                  lnk_fire;
  logic                  busy;
  logic                  eligible;
  logic [REQ_BITS-1:0]   winner;
  logic                  found;
  trn_bundle_t           src [NUM_REQ];
  trn_bundle_t           trn_out;

  rr_pick #(
    .NumReq  (NUM_REQ),
    .IdxBits (REQ_BITS)
  ) u_rr_pick (
    .req      (req_v),
    .last_idx (last_idx_q),
    .winner   (winner),
    .found    (found)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      src[i].td         = src_td[64*i +: 64];
      src[i].trem_n     = src_trem_n[8*i +: 8];
      src[i].tsof_n     = src_tsof_n[i];
      src[i].teof_n     = src_teof_n[i];
      src[i].tsrc_rdy_n = src_tsrc_rdy_n[i];
    end
  end

  assign busy     = (state_q == StBusy);
  assign eligible = found && !trn_lnk_up_n && (trn_tbuf_av >= 6'(MIN_TBUF));

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    last_idx_d  = last_idx_q;
    wdog_d      = wdog_q;
    wdog_fire   = 1'b0;
    lnk_fire    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (eligible) begin
          state_d     = StBusy;
          grant_d     = NUM_REQ'(1) << winner;
          grant_idx_d = winner;
          last_idx_d  = winner;
          wdog_d      = '0;
        end
      end
      StBusy: begin
        if (trn_lnk_up_n) begin
          lnk_fire = 1'b1;
          grant_d  = '0;
          state_d  = StGap;
        end else if (!trn_tdst_rdy_n) begin
          // Done takes priority over a watchdog expiry landing on the same beat.
          if (req_done[grant_idx_q]) begin
            grant_d = '0;
            state_d = StGap;
          end else if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
            wdog_fire = 1'b1;
            grant_d   = '0;
            state_d   = StGap;
          end else begin
            wdog_d = wdog_q + WDOG_W'(1);
          end
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  // A new error outranks a same-cycle clear.
  assign err_wdog_d = (err_wdog_q && !err_clr) || wdog_fire;
  assign err_lnk_d  = (err_lnk_q && !err_clr) || lnk_fire;

  always_ff @(posedge pcie_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      grant_idx_q <= '0;
      last_idx_q  <= REQ_BITS'(NUM_REQ - 1);
      wdog_q      <= '0;
      err_wdog_q  <= 1'b0;
      err_lnk_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      last_idx_q  <= last_idx_d;
      wdog_q      <= wdog_d;
      err_wdog_q  <= err_wdog_d;
      err_lnk_q   <= err_lnk_d;
    end
  end

  always_comb begin
    trn_out = TRN_IDLE;
    if (busy) begin
      trn_out = src[grant_idx_q];
    end
  end

  assign trn_td         = trn_out.td;
  assign trn_trem_n     = trn_out.trem_n;
  assign trn_tsof_n     = trn_out.tsof_n;
  assign trn_teof_n     = trn_out.teof_n;
  assign trn_tsrc_rdy_n = trn_out.tsrc_rdy_n;
  assign req_stall      = !busy || trn_tdst_rdy_n;
  assign req_grant      = grant_q;
  assign err_wdog       = err_wdog_q;
  assign err_lnk        = err_lnk_q;

endmodule

// File: tb/tb_pcie_tx_arb.sv
// Scoreboard bench for pcie_tx_arb: behavioural sources, expected-beat queue, directed scenarios.
module tb_pcie_tx_arb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [2:0]   req_v, req_done, req_grant;
  logic         req_stall;
  logic [191:0] src_td;
  logic [23:0]  src_trem_n;
  logic [2:0]   src_tsof_n, src_teof_n, src_tsrc_rdy_n;
  logic [63:0]  trn_td;
  logic [7:0]   trn_trem_n;
  logic         trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n;
  logic         trn_tdst_rdy_n;
  logic [5:0]   trn_tbuf_av;
  logic         trn_lnk_up_n;
  logic         err_wdog, err_lnk, err_clr;

  int pending[3];
  int beat[3];
  int len[3];
  int pkt[3];
  logic [73:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pcie_tx_arb #(
    .NUM_REQ     (3),
    .REQ_BITS    (2),
    .WDOG_CYCLES (16),
    .MIN_TBUF    (1)
  ) dut (
    .pcie_clk       (clk),
    .rst_n          (rst_n),
    .req_v          (req_v),
    .req_done       (req_done),
    .req_grant      (req_grant),
    .req_stall      (req_stall),
    .src_td         (src_td),
    .src_trem_n     (src_trem_n),
    .src_tsof_n     (src_tsof_n),
    .src_teof_n     (src_teof_n),
    .src_tsrc_rdy_n (src_tsrc_rdy_n),
    .trn_td         (trn_td),
    .trn_trem_n     (trn_trem_n),
    .trn_tsof_n     (trn_tsof_n),
    .trn_teof_n     (trn_teof_n),
    .trn_tsrc_rdy_n (trn_tsrc_rdy_n),
    .trn_tdst_rdy_n (trn_tdst_rdy_n),
    .trn_tbuf_av    (trn_tbuf_av),
    .trn_lnk_up_n   (trn_lnk_up_n),
    .err_wdog       (err_wdog),
    .err_lnk        (err_lnk),
    .err_clr        (err_clr)
  );

  // One beat as seen on TRN: {td, trem_n, tsof_n, teof_n}.
  function automatic logic [73:0] beat_rec(input int src, input int p, input int b, input int ln);
    logic [63:0] td;
    td = {8'hC0 + 8'(src), 8'(p), 16'(b), 32'h5A00_0000 + 32'(src * 4096 + p * 256 + b)};
    return {td, (b == ln - 1) ? 8'h0F : 8'h00, (b == 0) ? 1'b0 : 1'b1,
            (b == ln - 1) ? 1'b0 : 1'b1};
  endfunction

  logic [73:0] rec;
  always_comb begin
    rec            = '0;
    req_v          = '0;
    req_done       = '0;
    src_td         = '0;
    src_trem_n     = '0;
    src_tsof_n     = '1;
    src_teof_n     = '1;
    src_tsrc_rdy_n = '1;
    for (int i = 0; i < 3; i++) begin
      rec                   = beat_rec(i, pkt[i], beat[i], len[i]);
      src_td[64*i +: 64]    = rec[73:10];
      src_trem_n[8*i +: 8]  = rec[9:2];
      src_tsof_n[i]         = rec[1];
      src_teof_n[i]         = rec[0];
      req_v[i]              = pending[i] > 0;
      src_tsrc_rdy_n[i]     = !(pending[i] > 0);
      req_done[i]           = (pending[i] > 0) && (beat[i] == len[i] - 1);
    end
  end

  // Source driver: a beat advances when it was granted and unstalled at the sampling point.
  initial begin
    bit fire[3];
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) fire[i] = req_grant[i] && !req_stall && pending[i] > 0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (fire[i]) begin
          if (beat[i] == len[i] - 1) begin
            beat[i] = 0;
            pkt[i]++;
            pending[i]--;
          end else begin
            beat[i]++;
          end
        end
      end
    end
  end

  // Monitor: every accepted TRN beat is popped and compared against the scoreboard.
  initial begin
    logic [73:0] got, want;
    forever begin
      @(negedge clk);
      if (rst_n && !trn_tsrc_rdy_n && !trn_tdst_rdy_n) begin
        got = {trn_td, trn_trem_n, trn_tsof_n, trn_teof_n};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL beat: unexpected beat got %h", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_err++;
            $display("FAIL beat: got %h expected %h", got, want);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beats(input int src, input int p, input int first, input int n,
                            input int ln);
    for (int b = first; b < first + n; b++) exp_q.push_back(beat_rec(src, p, b, ln));
  endtask

  task automatic wait_grant(input int idx, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_grant[idx] && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_grant"}, 64'(req_grant[idx]), 64'd1);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((req_grant != 3'b000 || pending[0] + pending[1] + pending[2] != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, 64'(req_grant), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int order[$];
    logic [2:0] prev;
    logic [73:0] r;
    int cnt;

    for (int i = 0; i < 3; i++) begin
      pending[i] = 0; beat[i] = 0; len[i] = 1; pkt[i] = 0;
    end
    rst_n = 1'b0; err_clr = 1'b0;
    trn_tdst_rdy_n = 1'b0; trn_tbuf_av = 6'd8; trn_lnk_up_n = 1'b0;

    @(negedge clk);
    check("rst_grant", 64'(req_grant), 64'd0);
    check("rst_stall", 64'(req_stall), 64'd1);
    check("rst_td", trn_td, 64'd0);
    check("rst_trem", 64'(trn_trem_n), 64'hFF);
    check("rst_framing", 64'({trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n}), 64'h7);
    check("rst_err", 64'({err_wdog, err_lnk}), 64'd0);
    rst_n = 1'b1;

    // Round-robin: all sources, two 2-beat packets each.
    step();
    for (int i = 0; i < 3; i++) begin len[i] = 2; pending[i] = 2; end
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 3; s++) push_beats(s, p, 0, 2, 2);
    prev = '0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_grant != 3'b000 && req_grant != prev)
        order.push_back(req_grant[0] ? 0 : (req_grant[1] ? 1 : 2));
      prev = req_grant;
      if (req_grant == 3'b000 && pending[0] + pending[1] + pending[2] == 0) break;
    end
    check("rr_count", 64'(order.size()), 64'd6);
    for (int k = 0; k < 6 && k < order.size(); k++) check("rr_order", 64'(order[k]), 64'(k % 3));

    // Single source, 4 beats: grant one cycle after req_v, one GAP cycle after done.
    step();
    len[0] = 4; pending[0] = 1;
    push_beats(0, pkt[0], 0, 4, 4);
    @(negedge clk);
    check("single_lat0", 64'(req_grant), 64'd0);
    @(negedge clk);
    check("single_lat1", 64'(req_grant), 64'b001);
    repeat (3) @(negedge clk);
    check("single_last", 64'(req_grant), 64'b001);
    @(negedge clk);
    check("single_gap_grant", 64'(req_grant), 64'd0);
    check("single_gap_stall", 64'(req_stall), 64'd1);
    check("single_gap_tsrc", 64'(trn_tsrc_rdy_n), 64'd1);

    // Back-pressure for 3 cycles mid-packet; stalled cycles must not feed the watchdog.
    step();
    len[0] = 14; pending[0] = 1;
    push_beats(0, pkt[0], 0, 14, 14);
    wait_grant(0, "bp");
    step();
    @(negedge clk);
    step();
    trn_tdst_rdy_n = 1'b1;
    r = beat_rec(0, pkt[0], 2, 14);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_stall", 64'(req_stall), 64'd1);
      check("bp_td_held", trn_td, r[73:10]);
      check("bp_grant_held", 64'(req_grant), 64'b001);
      step();
    end
    trn_tdst_rdy_n = 1'b0;
    wait_idle("bp");
    check("bp_no_wdog", 64'(err_wdog), 64'd0);

    // Credit gating: no grant while tbuf_av is below the minimum.
    step();
    trn_tbuf_av = 6'd0; len[2] = 2; pending[2] = 1;
    push_beats(2, pkt[2], 0, 2, 2);
    repeat (4) begin
      @(negedge clk);
      check("credit_block", 64'(req_grant), 64'd0);
    end
    step();
    trn_tbuf_av = 6'd1;
    @(negedge clk);
    check("credit_lat0", 64'(req_grant), 64'd0);
    @(negedge clk);
    check("credit_lat1", 64'(req_grant), 64'b100);
    wait_idle("credit");

    // Link loss mid-packet.
    step();
    len[0] = 10; pending[0] = 1;
    push_beats(0, pkt[0], 0, 3, 10);
    wait_grant(0, "lnk");
    step();
    @(negedge clk);
    step();
    trn_lnk_up_n = 1'b1;
    @(negedge clk);
    check("lnk_hold", 64'(req_grant), 64'b001);
    @(negedge clk);
    check("lnk_drop", 64'(req_grant), 64'd0);
    check("lnk_err", 64'(err_lnk), 64'd1);
    check("lnk_tsrc", 64'(trn_tsrc_rdy_n), 64'd1);
    step();
    beat[0] = 0;
    repeat (3) begin
      @(negedge clk);
      check("lnk_idle_nogrant", 64'(req_grant), 64'd0);
    end
    step();
    pending[0] = 0; trn_lnk_up_n = 1'b0;
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    check("lnk_clr", 64'(err_lnk), 64'd0);

    // Watchdog: source 1 never finishes; source 2 must be granted after the forced release.
    step();
    len[1] = 1000; pending[1] = 1; len[2] = 2; pending[2] = 1;
    push_beats(1, pkt[1], 0, 16, 1000);
    push_beats(2, pkt[2], 0, 2, 2);
    wait_grant(1, "wd");
    cnt = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!req_grant[1]) break;
      cnt++;
    end
    check("wd_len", 64'(cnt), 64'd16);
    check("wd_err", 64'(err_wdog), 64'd1);
    check("wd_tsrc", 64'(trn_tsrc_rdy_n), 64'd1);
    step();
    pending[1] = 0; beat[1] = 0;
    wait_grant(2, "wd_next");
    wait_idle("wd");
    step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    @(negedge clk);
    check("wd_clr", 64'(err_wdog), 64'd0);

    // Asynchronous reset mid-packet, then arbitration restarts from index 0.
    step();
    len[1] = 8; pending[1] = 1;
    push_beats(1, pkt[1], 0, 1, 8);
    wait_grant(1, "rst");
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_grant", 64'(req_grant), 64'd0);
    check("arst_stall", 64'(req_stall), 64'd1);
    check("arst_td", trn_td, 64'd0);
    check("arst_trem", 64'(trn_trem_n), 64'hFF);
    check("arst_framing", 64'({trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n}), 64'h7);
    pending[1] = 0; beat[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    len[1] = 1; len[2] = 1; pending[1] = 1; pending[2] = 1;
    push_beats(1, pkt[1], 0, 1, 1);
    push_beats(2, pkt[2], 0, 1, 1);
    @(negedge clk);
    @(negedge clk);
    check("rr_restart", 64'(req_grant), 64'b010);
    wait_idle("rst");

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
